// File: rtl/grayscale_if.sv
// FIFO-side bundle for the grayscale stage: RGB read port and gray write port.
interface grayscale_if #(
  parameter int DWIDTH_IN  = 24,
  parameter int DWIDTH_OUT = 8
);
  logic                  in_rd_en;
  logic [DWIDTH_IN-1:0]  in_dout;
  logic                  in_empty;
  logic                  out_wr_en;
  logic [DWIDTH_OUT-1:0] out_din;
  logic                  out_full;

  modport master (
    output in_rd_en,
    input  in_dout,
    input  in_empty,
    output out_wr_en,
    output out_din,
    input  out_full
  );

  modport slave (
    input  in_rd_en,
    output in_dout,
    output in_empty,
    input  out_wr_en,
    input  out_din,
    output out_full
  );
endinterface

// File: rtl/grayscale.sv
// RGB to grayscale stage: averages R,G,B of one pixel every two cycles and
// tracks the pixel position to flag the end of each frame.
module grayscale #(
  parameter int DWIDTH_IN  = 24,
  parameter int DWIDTH_OUT = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  grayscale_if.master bus,
  output logic        frame_done
);
  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {
    S_READ,
    S_WRITE
  } state_t;

  state_t          r_state;
  logic [9:0]      r_sum;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;
  logic            r_fd;

  logic            w_rd;
  logic            w_wr;
  logic            w_xlast;
  logic            w_ylast;
  logic [9:0]      w_sum;
  logic [DWIDTH_OUT-1:0] w_gray;

  assign w_rd = (r_state == S_READ) && !bus.in_empty;
  assign w_wr = (r_state == S_WRITE) && !bus.out_full;

  assign w_sum = {2'b00, bus.in_dout[23:16]}
               + {2'b00, bus.in_dout[15:8]}
               + {2'b00, bus.in_dout[7:0]};

  // Max sum is 765, so the quotient never exceeds 255.
  assign w_gray = DWIDTH_OUT'(r_sum / 10'd3);

  assign w_xlast = (r_x == XW'(IMG_WIDTH - 1));
  assign w_ylast = (r_y == YW'(IMG_HEIGHT - 1));

  assign bus.in_rd_en  = w_rd;
  assign bus.out_wr_en = w_wr;
  assign bus.out_din   = w_gray;
  assign frame_done    = r_fd;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_READ;
      r_sum   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_fd <= 1'b0;
      unique case (r_state)
        S_READ: begin
          if (w_rd) begin
            r_sum   <= w_sum;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_wr) begin
            r_state <= S_READ;
            if (w_xlast) begin
              r_x <= '0;
              if (w_ylast) begin
                r_y  <= '0;
                r_fd <= 1'b1;
              end else begin
                r_y <= r_y + 1'b1;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        default: r_state <= S_READ;
      endcase
    end
  end
endmodule

// File: tb/tb_grayscale.sv
// Scoreboard bench for grayscale on a 4x2 frame: models the upstream FIFO,
// predicts gray values, write latency and frame_done pulses.
module tb_grayscale;
  localparam int W = 4;
  localparam int H = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fd;

  always #5 clk = ~clk;

  grayscale_if #(.DWIDTH_IN(24), .DWIDTH_OUT(8)) bus ();

  grayscale #(
    .DWIDTH_IN (24),
    .DWIDTH_OUT(8),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) u_dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus.master),
    .frame_done(fd)
  );

  logic [23:0] inq[$];
  logic [7:0]  sbq[$];
  int          latq[$];

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc_no = 0;
  int   stall = 0;
  int   wr_cnt = 0;
  int   fd_cnt = 0;
  int   mx = 0;
  int   my = 0;
  logic fd_exp = 1'b0;
  logic full_flag = 1'b0;
  logic o_rd, o_wr;
  logic [7:0] o_dout;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc_no);
    end
  endtask

  function automatic logic [7:0] gray_of(input logic [23:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return 8'(s / 3);
  endfunction

  task automatic cyc();
    logic [7:0] e;
    @(negedge clk);
    bus.in_empty = (inq.size() == 0);
    bus.in_dout  = (inq.size() != 0) ? inq[0] : 24'($urandom);
    bus.out_full = full_flag;
    #1;
    o_rd   = bus.in_rd_en;
    o_wr   = bus.out_wr_en;
    o_dout = bus.out_din;
    if (o_rd && o_wr) chk("rd_wr_both", 1, 0);
    fd_exp = 1'b0;
    if (o_wr) begin
      wr_cnt++;
      if (sbq.size() == 0) begin
        chk("spurious_wr", o_wr, 0);
      end else begin
        e = sbq.pop_front();
        chk("dout", o_dout, e);
        chk("lat", cyc_no - latq.pop_front(), 1 + stall);
      end
      if (mx == W - 1) begin
        mx = 0;
        if (my == H - 1) begin
          my = 0;
          fd_exp = 1'b1;
        end else my++;
      end else mx++;
    end else if (sbq.size() != 0 && full_flag) begin
      stall++;
    end
    if (o_rd) begin
      if (inq.size() == 0) begin
        chk("spurious_rd", o_rd, 0);
      end else begin
        sbq.push_back(gray_of(inq.pop_front()));
        latq.push_back(cyc_no);
        stall = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc_no++;
    if (fd) fd_cnt++;
    chk("frame_done", fd, fd_exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_empty = 1'b1;
    bus.out_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    inq.delete();
    sbq.delete();
    latq.delete();
    mx = 0;
    my = 0;
    stall = 0;
    full_flag = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inq.size() != 0 || sbq.size() != 0) && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_left", inq.size() + sbq.size(), 0);
  endtask

  initial begin
    logic [7:0] d0;
    int w0;
    int f0;
    bus.in_empty = 1'b1;
    bus.in_dout  = '0;
    bus.out_full = 1'b0;

    do_reset();
    #1;
    chk("rst_dout", bus.out_din, 0);
    chk("rst_fd", fd, 0);
    chk("rst_rd", bus.in_rd_en, 0);
    chk("rst_wr", bus.out_wr_en, 0);

    // single pixel, known value
    inq.push_back(24'h0A141E);
    cyc();
    chk("p1_rd", o_rd, 1);
    cyc();
    chk("p1_wr", o_wr, 1);
    chk("p1_dout", o_dout, 8'h14);

    // extremes
    inq.push_back(24'hFFFFFF);
    inq.push_back(24'h010100);
    drain();

    // downstream backpressure
    inq.push_back(24'h123456);
    inq.push_back(24'h654321);
    full_flag = 1'b1;
    cyc();
    chk("bp_rd", o_rd, 1);
    cyc();
    d0 = o_dout;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      chk("bp_wr", o_wr, 0);
      chk("bp_rd0", o_rd, 0);
      chk("bp_stable", o_dout, d0);
    end
    full_flag = 1'b0;
    w0 = wr_cnt;
    cyc();
    chk("bp_one_wr", wr_cnt - w0, 1);
    drain();

    // idle upstream
    repeat (10) begin
      cyc();
      chk("idle_rd", o_rd, 0);
      chk("idle_wr", o_wr, 0);
    end

    // two back-to-back frames from a clean start
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < 2 * W * H; i++) inq.push_back(24'($urandom));
    drain();
    cyc();
    chk("two_frames", fd_cnt, 2);

    // reset with a pixel pending in the write state
    for (int i = 0; i < W * H; i++) inq.push_back(24'($urandom));
    w0 = wr_cnt;
    f0 = 0;
    while (wr_cnt - w0 < 3 && f0 < 50) begin
      cyc();
      f0++;
    end
    cyc();
    chk("mid_pending", sbq.size(), 1);
    do_reset();
    fd_cnt = 0;
    for (int i = 0; i < W * H; i++) inq.push_back(24'($urandom));
    drain();
    cyc();
    chk("post_rst_frame", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded bound");
    $fatal(1);
  end
endmodule

// File: doc/grayscale.md
GRAYSCALE -- requirements
Module: grayscale

Interface
REQ-001 SHALL have parameter DWIDTH_IN, default 24, meaning input pixel width: R in [23:16], G in [15:8], B in [7:0].
REQ-002 SHALL have parameter DWIDTH_OUT, default 8, meaning output grayscale pixel width.
REQ-003 SHALL have parameter IMG_WIDTH, default 720, meaning pixels per line.
REQ-004 SHALL have parameter IMG_HEIGHT, default 540, meaning lines per frame.
REQ-005 SHALL have port clock, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, meaning synchronous, active-high reset.
REQ-007 SHALL have port in_rd_en, output, 1 bit, meaning read strobe to the upstream RGB FIFO.
REQ-008 SHALL have port in_dout, input, DWIDTH_IN bits, meaning RGB pixel presented by the upstream FIFO.
REQ-009 SHALL have port in_empty, input, 1 bit, meaning the upstream FIFO has no data.
REQ-010 SHALL have port out_wr_en, output, 1 bit, meaning write strobe to the downstream gray FIFO that feeds sobel.
REQ-011 SHALL have port out_din, output, DWIDTH_OUT bits, meaning grayscale pixel to the downstream FIFO.
REQ-012 SHALL have port out_full, input, 1 bit, meaning the downstream FIFO cannot accept data.
REQ-013 SHALL have port frame_done, output, 1 bit, meaning one-cycle pulse after the last pixel of a frame is written.

Function
REQ-014 SHALL implement a two-state FSM: S_READ and S_WRITE; reset state S_READ.
REQ-015 In S_READ, if in_empty=0: drive in_rd_en=1 that cycle, register sum = R+G+B (10 bits, zero-extended, no overflow), next state S_WRITE.
REQ-016 In S_READ, if in_empty=1: in_rd_en=0, no register change, stay in S_READ.
REQ-017 out_din SHALL equal floor(sum/3) of the registered sum at all times; max result 255, so it always fits in 8 bits.
REQ-018 In S_WRITE, if out_full=0: drive out_wr_en=1 that cycle, advance pixel counters, next state S_READ.
REQ-019 In S_WRITE, if out_full=1: out_wr_en=0, hold sum and out_din, stay in S_WRITE; no input is read.
REQ-020 in_rd_en and out_wr_en SHALL be combinational from state and the FIFO flags, never asserted in the same cycle.
REQ-021 Throughput: at most one pixel per 2 cycles; latency is 1 cycle from in_rd_en to the earliest out_wr_en for that pixel.
REQ-022 Column counter x SHALL span 0..IMG_WIDTH-1 and row counter y SHALL span 0..IMG_HEIGHT-1; both are sized by clog2 and advance only on a write.
REQ-023 On a write with x=IMG_WIDTH-1: x wraps to 0 and y increments; if y=IMG_HEIGHT-1 as well, both wrap to 0.
REQ-024 frame_done SHALL be registered, high for exactly the cycle after the write of pixel (IMG_WIDTH-1, IMG_HEIGHT-1), and low otherwise.
REQ-025 Frames SHALL be processed back-to-back with no idle cycle inserted at the frame boundary.
REQ-026 Input data SHALL be sampled only in a cycle where in_rd_en=1; in_dout is ignored otherwise.

Reset
REQ-027 While reset=1 at a clock edge: state=S_READ, sum=0, x=0, y=0, frame_done=0.
REQ-028 During and after reset: in_rd_en=0 and out_wr_en=0 until the first S_READ cycle with in_empty=0; out_din=0.
REQ-029 Reset asserted mid-frame, including in S_WRITE with a pending pixel, SHALL discard that pixel; the next written pixel is (0,0).

Verification
REQ-030 Push RGB 0x0A141E with out_full=0 -> one in_rd_en, then out_wr_en with out_din=0x14 on the next cycle.
REQ-031 Push 0xFFFFFF and then 0x010100 -> out_din values 0xFF and 0x00, in that order.
REQ-032 Hold out_full=1 for 5 cycles after a read -> out_wr_en stays 0, out_din is stable, in_rd_en stays 0; releasing out_full gives exactly one write.
REQ-033 With in_empty=1 continuously -> in_rd_en and out_wr_en remain 0 and the counters do not move.
REQ-034 With IMG_WIDTH=4 and IMG_HEIGHT=2, stream 16 pixels -> frame_done pulses once after the 8th write and once after the 16th write.
REQ-035 Assert reset after 3 of 8 pixels of a frame, then stream 8 pixels -> frame_done pulses after the 8th post-reset write only.
